// File: rtl/aes_stat_wr_pkg.sv
// Shared constants and types for the AES status-word write sequencer.
//   BW     : byte width in bits (register file data width)
//   NB     : bytes per status word (register file depth)
//   AW     : register address width, clog2(NB)
//   WCNT_W : width of the completed-word counter
package aes_stat_wr_pkg;

    localparam int unsigned BW     = 8;
    localparam int unsigned NB     = 4;
    localparam int unsigned AW     = 2;
    localparam int unsigned WCNT_W = 16;

    // Status word viewed as NB bytes; element i goes to register address i.
    typedef logic [NB-1:0][BW-1:0] word_t;

    // Status word payload as held in the active and hold registers.
    typedef struct packed {
        word_t          data;
        logic [NB-1:0]  mask;
    } stat_t;

    // Index of the lowest set bit of an NB-bit mask (0 when the mask is empty).
    function automatic logic [AW-1:0] lowest_set(input logic [NB-1:0] m);
        lowest_set = '0;
        for (int i = int'(NB) - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_set = AW'(i);
            end
        end
    endfunction

endpackage

// File: rtl/aes_stat_wr_pick.sv
// Combinational priority pick of the next byte to write.
//   mask_i  : remaining byte-write mask
//   idx_o   : index of the lowest set bit
//   found_o : mask has at least one bit set
//   rest_o  : mask with the picked bit cleared
module aes_stat_wr_pick
    import aes_stat_wr_pkg::*;
(
    input  logic [NB-1:0] mask_i,
    output logic [AW-1:0] idx_o,
    output logic          found_o,
    output logic [NB-1:0] rest_o
);

    assign idx_o   = lowest_set(mask_i);
    assign found_o = |mask_i;
    // m & (m-1) clears the lowest set bit; an empty mask stays empty.
    assign rest_o  = mask_i & (mask_i - NB'(1));

endmodule

// File: rtl/aes_stat_wr.sv
// Write sequencer in front of the AES status register file. Accepts whole
// status words over valid/ready and issues one masked byte write per clock,
// with a one-entry hold buffer so the next word can be posted early.
//   clk, rstn        : clock, asynchronous active-low reset
//   flush            : synchronous abort of active and held words
//   s_valid/s_ready  : status word handshake (s_ready = hold buffer empty)
//   s_data, s_mask   : status word and per-byte write enables
//   m_en/m_we/m_aw/m_din : register file write port
//   busy             : an active word is present
//   done             : one-cycle pulse with the last write of a word
//   wcnt             : completed-word counter (wraps)
module aes_stat_wr
    import aes_stat_wr_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [NB*BW-1:0]  s_data,
    input  logic [NB-1:0]     s_mask,
    output logic              m_en,
    output logic              m_we,
    output logic [AW-1:0]     m_aw,
    output logic [BW-1:0]     m_din,
    output logic              busy,
    output logic              done,
    output logic [WCNT_W-1:0] wcnt
);

    stat_t              act_q,      act_d;
    logic               act_vld_q,  act_vld_d;
    stat_t              hold_q,     hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic               m_en_q,     m_en_d;
    logic [AW-1:0]      m_aw_q,     m_aw_d;
    logic [BW-1:0]      m_din_q,    m_din_d;
    logic               done_q,     done_d;
    logic [WCNT_W-1:0]  wcnt_q,     wcnt_d;

    logic [AW-1:0]      pick_idx;
    logic               pick_found;
    logic [NB-1:0]      pick_rest;

    logic               accept;
    logic               issue;
    logic               last;
    logic               act_free;
    stat_t              in_word;

    aes_stat_wr_pick u_pick (
        .mask_i  (act_q.mask),
        .idx_o   (pick_idx),
        .found_o (pick_found),
        .rest_o  (pick_rest)
    );

    assign accept   = s_valid && !hold_vld_q;
    assign issue    = act_vld_q && pick_found;
    // Completion edge: the byte being issued is the last one, or the mask was empty.
    assign last     = act_vld_q && (pick_rest == '0);
    assign act_free = !act_vld_q || last;
    assign in_word  = '{data: word_t'(s_data), mask: s_mask};

    // Next-state: byte issue, completion, active/hold refill.
    always_comb begin
        act_d      = act_q;
        act_vld_d  = act_vld_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        m_en_d     = 1'b0;
        m_aw_d     = m_aw_q;
        m_din_d    = m_din_q;
        done_d     = 1'b0;
        wcnt_d     = wcnt_q;

        if (flush) begin
            // Flush wins over accept; any word offered this cycle is dropped.
            act_vld_d  = 1'b0;
            hold_vld_d = 1'b0;
        end else begin
            if (issue) begin
                m_en_d     = 1'b1;
                m_aw_d     = pick_idx;
                m_din_d    = act_q.data[pick_idx];
                act_d.mask = pick_rest;
            end
            if (last) begin
                done_d = 1'b1;
                wcnt_d = wcnt_q + WCNT_W'(1);
            end
            // Refill active on the completion edge so the next word has no bubble.
            if (act_free) begin
                if (hold_vld_q) begin
                    act_d      = hold_q;
                    act_vld_d  = 1'b1;
                    hold_vld_d = 1'b0;
                end else if (accept) begin
                    act_d     = in_word;
                    act_vld_d = 1'b1;
                end else begin
                    act_vld_d = 1'b0;
                end
            end else if (accept) begin
                hold_d     = in_word;
                hold_vld_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_q      <= '0;
            act_vld_q  <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            m_en_q     <= 1'b0;
            m_aw_q     <= '0;
            m_din_q    <= '0;
            done_q     <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            act_q      <= act_d;
            act_vld_q  <= act_vld_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            m_en_q     <= m_en_d;
            m_aw_q     <= m_aw_d;
            m_din_q    <= m_din_d;
            done_q     <= done_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign s_ready = !hold_vld_q;
    assign m_en    = m_en_q;
    assign m_we    = m_en_q;
    assign m_aw    = m_aw_q;
    assign m_din   = m_din_q;
    assign busy    = act_vld_q;
    assign done    = done_q;
    assign wcnt    = wcnt_q;

endmodule

// File: tb/tb_aes_stat_wr.sv
// Scoreboard bench for aes_stat_wr: expected register-file writes are queued
// when a word is accepted and checked on every strobe/done cycle.
module tb_aes_stat_wr;
    import aes_stat_wr_pkg::*;

    logic              clk;
    logic              rstn;
    logic              flush;
    logic              s_valid;
    logic              s_ready;
    logic [NB*BW-1:0]  s_data;
    logic [NB-1:0]     s_mask;
    logic              m_en;
    logic              m_we;
    logic [AW-1:0]     m_aw;
    logic [BW-1:0]     m_din;
    logic              busy;
    logic              done;
    logic [WCNT_W-1:0] wcnt;

    aes_stat_wr dut (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_mask  (s_mask),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_aw    (m_aw),
        .m_din   (m_din),
        .busy    (busy),
        .done    (done),
        .wcnt    (wcnt)
    );

    typedef struct packed {
        logic          en;
        logic [AW-1:0] aw;
        logic [BW-1:0] din;
        logic          done;
    } exp_t;

    exp_t exp_q[$];
    int   strobe_cyc[$];
    int   checks;
    int   errors;
    int   cyc;
    int   last_done_cyc;
    int   exp_wcnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every strobe or done pulse must match the next queued entry.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            checks++;
            if (m_we !== m_en) begin
                errors++;
                $display("FAIL we_eq_en: m_we=%b m_en=%b", m_we, m_en);
            end
            if (m_en === 1'b1 || done === 1'b1) begin
                exp_t e;
                if (m_en === 1'b1) strobe_cyc.push_back(cyc);
                if (done === 1'b1) last_done_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: en=%b aw=%0d din=%h done=%b, none expected",
                             m_en, m_aw, m_din, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.en) begin
                        if ({m_en, m_aw, m_din, done} !== e) begin
                            errors++;
                            $display("FAIL strobe: got en=%b aw=%0d din=%h done=%b, expected en=1 aw=%0d din=%h done=%b",
                                     m_en, m_aw, m_din, done, e.aw, e.din, e.done);
                        end
                    end else if ({m_en, done} !== 2'b01) begin
                        errors++;
                        $display("FAIL zero_mask_done: got en=%b done=%b, expected en=0 done=1", m_en, done);
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [NB*BW-1:0] d, input logic [NB-1:0] m);
        int   last;
        exp_t e;
        last = -1;
        for (int i = 0; i < int'(NB); i++) if (m[i]) last = i;
        if (last < 0) begin
            e      = '0;
            e.done = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < int'(NB); i++) begin
                if (m[i]) begin
                    e.en   = 1'b1;
                    e.aw   = AW'(i);
                    e.din  = d[i*BW +: BW];
                    e.done = (i == last);
                    exp_q.push_back(e);
                end
            end
        end
        exp_wcnt++;
    endtask

    // Offer a word, wait for s_ready, return after the accepting edge.
    task automatic send_word(input logic [NB*BW-1:0] d, input logic [NB-1:0] m,
                             output int waits, output int acc_cyc);
        s_data  = d;
        s_mask  = m;
        s_valid = 1'b1;
        waits   = 0;
        acc_cyc = -1;
        while (!s_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL accept_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, waits);
        end else begin
            push_word(d, m);
            @(posedge clk); #1;
            acc_cyc = cyc;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d busy=%b, expected 0 and 0", name, exp_q.size(), busy);
        end
    endtask

    task automatic check_wcnt(input string name);
        checks++;
        if (wcnt !== WCNT_W'(exp_wcnt)) begin
            errors++;
            $display("FAIL %s_wcnt: got %0d expected %0d", name, wcnt, exp_wcnt);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({m_en, m_we, m_aw, m_din, busy, done, wcnt, s_ready} !==
            {1'b0, 1'b0, AW'(0), BW'(0), 1'b0, 1'b0, WCNT_W'(0), 1'b1}) begin
            errors++;
            $display("FAIL reset_values: en=%b we=%b aw=%0d din=%h busy=%b done=%b wcnt=%0d rdy=%b, expected 0 0 0 00 0 0 0 1",
                     m_en, m_we, m_aw, m_din, busy, done, wcnt, s_ready);
        end
        @(negedge clk); #1;
        rstn = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_single();
        int w, acc, base;
        base = strobe_cyc.size();
        send_word(32'h4433_2211, 4'hF, w, acc);
        wait_idle("single");
        checks++;
        if (strobe_cyc.size() != base + 4) begin
            errors++;
            $display("FAIL single_count: got %0d strobes expected 4", strobe_cyc.size() - base);
        end else if (strobe_cyc[base] != acc + 1 || strobe_cyc[base+3] != acc + 4) begin
            errors++;
            $display("FAIL single_latency: first/last strobe cycle %0d/%0d expected %0d/%0d",
                     strobe_cyc[base], strobe_cyc[base+3], acc + 1, acc + 4);
        end
        check_wcnt("single");
    endtask

    task automatic test_sparse();
        int w, acc, base;
        base = strobe_cyc.size();
        send_word(32'hDDCC_BBAA, 4'hA, w, acc);
        wait_idle("sparse");
        checks++;
        if (strobe_cyc.size() != base + 2) begin
            errors++;
            $display("FAIL sparse_count: got %0d strobes expected 2", strobe_cyc.size() - base);
        end
        check_wcnt("sparse");
    endtask

    task automatic test_zero_mask();
        int w, acc, base;
        base = strobe_cyc.size();
        send_word(32'h1234_5678, 4'h0, w, acc);
        wait_idle("zero");
        checks++;
        if (strobe_cyc.size() != base || last_done_cyc != acc + 1) begin
            errors++;
            $display("FAIL zero_timing: strobes=%0d done_cyc=%0d, expected 0 strobes and done_cyc=%0d",
                     strobe_cyc.size() - base, last_done_cyc, acc + 1);
        end
        check_wcnt("zero");
    endtask

    task automatic test_back_to_back();
        int w, acc, base;
        base = strobe_cyc.size();
        send_word(32'h0403_0201, 4'hF, w, acc);
        send_word(32'h1413_1211, 4'hF, w, acc);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_drop: s_ready=%b expected 0", s_ready);
        end
        send_word(32'h2423_2221, 4'hF, w, acc);
        checks++;
        if (w != 3) begin
            errors++;
            $display("FAIL b2b_wait: third word waited %0d cycles expected 3", w);
        end
        wait_idle("b2b");
        checks++;
        if (strobe_cyc.size() != base + 12) begin
            errors++;
            $display("FAIL b2b_count: got %0d strobes expected 12", strobe_cyc.size() - base);
        end else if (strobe_cyc[base+11] - strobe_cyc[base] != 11) begin
            errors++;
            $display("FAIL b2b_bubble: 12 strobes span %0d cycles expected 12",
                     strobe_cyc[base+11] - strobe_cyc[base] + 1);
        end
        check_wcnt("b2b");
    endtask

    task automatic test_flush();
        int w, acc, base, n;
        base = strobe_cyc.size();
        send_word(32'h0F0E_0D0C, 4'hF, w, acc);
        send_word(32'h1B1A_1918, 4'hF, w, acc);
        n = 0;
        while (strobe_cyc.size() < base + 2 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        flush = 1'b1;
        exp_q.delete();
        exp_wcnt -= 2;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if ({m_en, busy, s_ready, done} !== 4'b0010) begin
            errors++;
            $display("FAIL flush_state: en=%b busy=%b rdy=%b done=%b, expected 0 0 1 0",
                     m_en, busy, s_ready, done);
        end
        check_wcnt("flush");
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (strobe_cyc.size() != base + 2) begin
            errors++;
            $display("FAIL flush_strobes: got %0d strobes expected 2", strobe_cyc.size() - base);
        end
    endtask

    task automatic test_async_reset();
        int w, acc, base, n;
        base = strobe_cyc.size();
        send_word(32'h8765_4321, 4'hF, w, acc);
        n = 0;
        while (strobe_cyc.size() < base + 3 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        rstn = 1'b0;
        exp_q.delete();
        exp_wcnt = 0;
        #1;
        checks++;
        if ({m_en, busy, done, s_ready} !== 4'b0001 || wcnt !== WCNT_W'(0)) begin
            errors++;
            $display("FAIL async_reset: en=%b busy=%b done=%b rdy=%b wcnt=%0d, expected 0 0 0 1 0",
                     m_en, busy, done, s_ready, wcnt);
        end
        @(negedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        send_word(32'hA1B2_C3D4, 4'hF, w, acc);
        wait_idle("post_reset");
        check_wcnt("post_reset");
    endtask

    initial begin
        rstn          = 1'b0;
        flush         = 1'b0;
        s_valid       = 1'b0;
        s_data        = '0;
        s_mask        = '0;
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        last_done_cyc = -1;
        exp_wcnt      = 0;

        test_reset();
        test_single();
        test_sparse();
        test_zero_mask();
        test_back_to_back();
        test_flush();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
